// File: rtl/burst_clk_gen.sv
// burst_clk_gen: frame-armed, start-triggered multi-channel burst clock generator.
// Ports:
//   clk       - system clock, all logic on rising edge
//   reset     - asynchronous active-low reset
//   f0        - async frame strobe, falling edge arms a burst (IDLE only)
//   c4        - async start strobe, falling edge starts an armed burst
//   pulse_cnt - per-channel pulse counts, channel k at [k*CNT_W +: CNT_W]
//   half_div  - clk cycles per clk_out high and low phase (0 treated as 1)
//   ovr_clr   - synchronous clear of ovr
//   clk_en    - per-channel burst enable window
//   clk_out   - per-channel burst clock
//   busy      - high while ARMED or BURST
//   done      - one-cycle pulse when a burst completes
//   ovr       - sticky flag: f0 fall seen while ARMED or BURST
module burst_clk_gen #(
  parameter int NCH   = 2,
  parameter int CNT_W = 6,
  parameter int DIV_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f0,
  input  logic                 c4,
  input  logic [NCH*CNT_W-1:0] pulse_cnt,
  input  logic [DIV_W-1:0]     half_div,
  input  logic                 ovr_clr,
  output logic [NCH-1:0]       clk_en,
  output logic [NCH-1:0]       clk_out,
  output logic                 busy,
  output logic                 done,
  output logic                 ovr
);
  typedef enum logic [1:0] {IDLE, ARMED, BURST} state_t;
  state_t r_state, w_next;
  // bit0 = FF1, bit1 = FF2, bit2 = edge register
  logic [2:0]           r_f0_sync, r_c4_sync;
  logic [NCH*CNT_W-1:0] r_n;
  logic [DIV_W-1:0]     r_h, r_ph;
  logic                 r_hi;
  logic [CNT_W-1:0]     r_cnt [NCH];
  logic                 w_f0_fall, w_c4_fall, w_last, w_end_low;
  assign w_f0_fall = !r_f0_sync[1] && r_f0_sync[2];
  assign w_c4_fall = !r_c4_sync[1] && r_c4_sync[2];
  assign w_end_low = r_state == BURST && r_ph == '0 && !r_hi;
  assign busy = r_state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_f0_sync <= '1;
      r_c4_sync <= '1;
    end else begin
      r_f0_sync <= {r_f0_sync[1:0], f0};
      r_c4_sync <= {r_c4_sync[1:0], c4};
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_f0_fall) w_next = ARMED;
      ARMED:   if (w_c4_fall) w_next = (r_n == '0) ? IDLE : BURST;
      BURST:   if (w_end_low && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // A channel is still active while its remaining-pulse counter is nonzero;
  // the counter drops at the end of each low phase, so clk_en falls exactly
  // when the last low phase ends.
  always_comb begin
    w_last  = 1'b1;
    clk_en  = '0;
    clk_out = '0;
    for (int k = 0; k < NCH; k++) begin
      w_last     = w_last && (r_cnt[k] <= CNT_W'(1));
      clk_en[k]  = r_state == ARMED || (r_state == BURST && r_cnt[k] != '0);
      clk_out[k] = r_state == BURST && r_hi && r_cnt[k] != '0;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_n  <= '0;
      r_h  <= DIV_W'(1);
      r_ph <= '0;
      r_hi <= 1'b0;
      for (int k = 0; k < NCH; k++) r_cnt[k] <= '0;
    end else begin
      if (r_state == IDLE && w_f0_fall) begin
        r_n <= pulse_cnt;
        r_h <= (half_div == '0) ? DIV_W'(1) : half_div;
      end
      if (r_state == ARMED && w_c4_fall) begin
        r_ph <= r_h - DIV_W'(1);
        r_hi <= 1'b1;
        for (int k = 0; k < NCH; k++) r_cnt[k] <= r_n[k*CNT_W +: CNT_W];
      end else if (r_state == BURST) begin
        if (r_ph != '0) r_ph <= r_ph - DIV_W'(1);
        else begin
          r_ph <= r_h - DIV_W'(1);
          r_hi <= !r_hi;
          if (!r_hi)
            for (int k = 0; k < NCH; k++)
              if (r_cnt[k] != '0) r_cnt[k] <= r_cnt[k] - CNT_W'(1);
        end
      end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      done <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      done <= r_state != IDLE && w_next == IDLE;
      ovr  <= (w_f0_fall && r_state != IDLE) ? 1'b1 : ovr_clr ? 1'b0 : ovr;
    end
endmodule

// File: doc/burst_clk_gen.md
BURST_CLK_GEN -- requirements
Module: burst_clk_gen

Interface
REQ-001 SHALL have parameter NCH, default 2: number of burst-clock channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 6: pulse-count field width per channel.
REQ-003 SHALL have parameter DIV_W, default 4: half-period divider width.
REQ-004 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port f0  input  1: asynchronous frame strobe; falling edge arms a burst.
REQ-007 SHALL have port c4  input  1: asynchronous start strobe; falling edge starts an armed burst.
REQ-008 SHALL have port pulse_cnt  input  NCH*CNT_W: pulses per channel; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-009 SHALL have port half_div  input  DIV_W: clk cycles per clk_out high phase and per low phase.
REQ-010 SHALL have port ovr_clr  input  1: synchronous clear of ovr.
REQ-011 SHALL have port clk_en  output  NCH: per-channel burst-enable window.
REQ-012 SHALL have port clk_out  output  NCH: per-channel generated burst clock.
REQ-013 SHALL have port busy  output  1: high in ARMED or BURST.
REQ-014 SHALL have port done  output  1: one-cycle pulse at burst completion.
REQ-015 SHALL have port ovr  output  1: sticky overrun flag.

Function
REQ-016 SHALL pass f0 and c4 each through a 2-FF synchroniser plus an edge register; a falling edge is detected when FF2=0 and the edge register=1.
REQ-017 SHALL implement FSM IDLE -> ARMED on f0 fall; ARMED -> BURST on c4 fall; BURST -> IDLE when every channel's pulse counter reaches zero.
REQ-018 SHALL, when f0 is first sampled low at edge k in IDLE, enter ARMED and drive clk_en to all ones at edge k+2.
REQ-019 SHALL latch pulse_cnt and half_div on the IDLE->ARMED transition; input changes afterwards SHALL NOT affect the burst in progress.
REQ-020 SHALL treat a latched half_div of 0 as 1.
REQ-021 SHALL, on the edge entering BURST, drive clk_out high for every channel with a nonzero latched count.
REQ-022 SHALL hold each clk_out high for H cycles, then low for H cycles, per pulse (H = latched half_div), with all channels phase-aligned.
REQ-023 SHALL deassert clk_en[k] on the edge ending channel k's last low phase, i.e. 2*N_k*H cycles after BURST entry.
REQ-024 SHALL deassert clk_en[k] on the BURST entry edge when N_k = 0, and never pulse clk_out[k] for it.
REQ-025 SHALL return to IDLE and pulse done for one cycle on the edge the last clk_en bit falls; if every N_k = 0, this occurs on the BURST entry edge.
REQ-026 SHALL ignore a c4 fall in IDLE or BURST.
REQ-027 SHALL ignore an f0 fall in ARMED or BURST and set ovr (no restart, no relatch).
REQ-028 SHALL accept only f0 when f0 and c4 falls are detected in the same IDLE cycle; c4 is discarded.
REQ-029 SHALL clear ovr when ovr_clr=1; a simultaneous ovr set SHALL win.
REQ-030 SHALL use a shared phase counter of DIV_W bits and per-channel pulse counters of CNT_W bits, all non-wrapping.

Reset
REQ-031 SHALL, while reset=0, force state IDLE, clk_en=0, clk_out=0, busy=0, done=0, ovr=0, all counters and synchronisers to their idle values (synchroniser FFs =1).
REQ-032 SHALL abort an in-progress burst immediately on reset assertion, with no completion done pulse.
REQ-033 SHALL require a fresh f0 fall after reset release before any burst starts.

Verification
REQ-034 SHALL test NCH=2, counts {32,5}, half_div=1, f0 fall then c4 fall -> ch0 gives 32 pulses with clk_en for 64 cycles, ch1 gives 5 pulses over 10 cycles, then done one cycle.
REQ-035 SHALL test half_div=0 and half_div=3 with count 4 -> period 2 and 6 cycles respectively, 4 pulses each.
REQ-036 SHALL test count {0,3} -> clk_en[0] falls at BURST entry with no pulses; ch1 gives 3 pulses; done once.
REQ-037 SHALL test an f0 fall mid-burst -> burst unaffected, ovr=1 until ovr_clr; a c4 fall in IDLE -> no activity.
REQ-038 SHALL test reset asserted mid-burst -> all outputs 0 asynchronously, no done pulse; then c4 alone -> no burst.
